heap_object_writer: RTL and testbench
=====================================

Name: heap_object_writer

Overview:
- Allocates and writes Lisp objects into the shared word-addressed memory, in the exact layout the core's object fetcher reads.
  - Tag word at the base address, then the field words.
- Used by eval/apply when building results (numbers, cons cells, primitive function refs).
- Owns a bump-pointer heap and returns the new object's address.
- Memory access goes through an external arbiter grant, because the memory controller is single-port and shared with the fetcher.

Parameters:
- ADDR_WIDTH, 16, memory address width (matches lisp::addr_width).
- DATA_WIDTH, 16, memory word width (matches lisp::data_width).
- HEAP_BASE, 16'h0100, first heap address; reset value of the heap pointer.
- HEAP_LIMIT, 16'h0200, exclusive end of heap; an object may end exactly at HEAP_LIMIT-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  allocation request
- alloc_ready  out  1  writer idle, able to accept a request
- alloc_tag  in  DATA_WIDTH  object type tag (lisp::TYPE_*)
- alloc_field0  in  DATA_WIDTH  value / car / primitive body
- alloc_field1  in  DATA_WIDTH  cdr (cons only; ignored otherwise)
- done  out  1  one-cycle pulse: object fully written
- done_addr  out  ADDR_WIDTH  address of the most recently completed object
- error  out  1  sticky error flag
- error_code  out  2  0=none, 1=BAD_TAG, 2=OUT_OF_MEMORY
- heap_ptr  out  ADDR_WIDTH  next free address
- mem_grant  in  1  arbiter grants the memory port this cycle
- mem_req  out  1  writer wants the memory port
- mem_addr  out  ADDR_WIDTH  write address
- mem_write_enable  out  1  write strobe
- mem_write_data  out  DATA_WIDTH  write data

Behaviour:
- Reset values: alloc_ready=1, done=0, done_addr=0, error=0, error_code=0, heap_ptr=HEAP_BASE, mem_req=0, mem_write_enable=0, mem_addr=0, mem_write_data=0.
- Reset mid-operation aborts immediately; partially written words stay in memory and the heap pointer returns to HEAP_BASE.

Handshake:
- Accept when alloc_valid && alloc_ready (cycle N); alloc_tag and both fields are latched at that edge.
- alloc_ready=1 only in IDLE. Inputs are ignored in every other state.

State machine: IDLE, CHECK, WR_TAG, WR_F0, WR_F1, DONE, ERR.
- IDLE -> CHECK on accept.
- CHECK (N+1), compute size from the latched tag:
  - TYPE_NUMBER = 2 words.
  - TYPE_CONS = 3 words.
  - TYPE_FUNC_PRIM = 2 words.
  - Any other tag -> ERR with code BAD_TAG.
  - If heap_ptr + size > HEAP_LIMIT -> ERR with code OUT_OF_MEMORY. Compare at ADDR_WIDTH+1 bits so wrap-around cannot pass.
  - BAD_TAG takes priority over OUT_OF_MEMORY.
  - Otherwise -> WR_TAG.
- WR_TAG:
  - mem_req=1, mem_addr=heap_ptr, mem_write_data=tag.
  - mem_write_enable = mem_grant.
  - Advance to WR_F0 only when mem_grant=1; otherwise hold with outputs stable.
- WR_F0: same stall rule; addr=heap_ptr+1, data=field0.
  - Next state: WR_F1 for cons, else DONE.
- WR_F1: same stall rule; addr=heap_ptr+2, data=field1 -> DONE.
- DONE:
  - done=1 for exactly one cycle.
  - done_addr <= heap_ptr (the old value).
  - heap_ptr <= heap_ptr + size.
  - -> IDLE.
- ERR:
  - error=1; error_code held; alloc_ready=0; no memory activity.
  - Sticky until rst.
- mem_* outputs are 0 outside the WR_* states. mem_write_enable is never asserted without mem_grant.

Latency with mem_grant tied high:
- Number / primitive: done at N+4.
- Cons: done at N+5.
- Each cycle of denied grant adds one cycle.

Back-to-back: the next request can be accepted in the cycle after DONE, and it sees the updated heap_ptr.

Test Plan:
- Number alloc: tag=TYPE_NUMBER, field0=16'h002A, grant high -> writes [0x100]=TYPE_NUMBER, [0x101]=0x002A; done at N+4 with done_addr=0x100; heap_ptr=0x102.
- Back-to-back cons after the number: field0=0x0100, field1=0x0000 -> writes 0x102..0x104 on consecutive cycles; done_addr=0x102; heap_ptr=0x105; readback through the fetcher yields car=0x0100, cdr=0.
- Grant stall: cons with mem_grant low for 3 cycles during WR_F0 -> no write strobe while low, addr/data stable; done at N+8.
- Bad tag: alloc_tag=16'hBEEF -> no memory writes; error=1 and error_code=1 from N+2; alloc_ready stays 0 and later requests are ignored.
- OOM boundary: HEAP_BASE=0x100, HEAP_LIMIT=0x106. Two cons requests succeed (second ends at 0x105, heap_ptr=0x106). A following number request gives error_code=2, no write, heap_ptr stays 0x106.
- Reset mid-write: assert rst during WR_F0 of a cons -> next cycle alloc_ready=1, heap_ptr=HEAP_BASE, error=0, no done pulse.

Source files
------------

// File: rtl/heap_object_writer_if.sv
// Allocation request/response and shared-memory write port of the heap object writer.
// The writer uses the slave modport; the requester/arbiter side uses master.
interface heap_object_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [DATA_WIDTH-1:0] alloc_tag;
  logic [DATA_WIDTH-1:0] alloc_field0;
  logic [DATA_WIDTH-1:0] alloc_field1;
  logic                  done;
  logic [ADDR_WIDTH-1:0] done_addr;
  logic                  error;
  logic [1:0]            error_code;
  logic [ADDR_WIDTH-1:0] heap_ptr;
  logic                  mem_grant;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport master (
    output alloc_valid, alloc_tag, alloc_field0, alloc_field1, mem_grant,
    input  alloc_ready, done, done_addr, error, error_code, heap_ptr,
           mem_req, mem_addr, mem_write_enable, mem_write_data
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_field0, alloc_field1, mem_grant,
    output alloc_ready, done, done_addr, error, error_code, heap_ptr,
           mem_req, mem_addr, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/heap_object_writer.sv
// Bump-pointer allocator: writes tag word then field words at heap_ptr through an arbitrated port.
// Number/primitive done 4 cycles after accept, cons 5; every denied grant cycle adds one.
module heap_object_writer #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE      = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT     = 16'h0200,
  parameter logic [DATA_WIDTH-1:0] TYPE_NUMBER    = 16'h0001,
  parameter logic [DATA_WIDTH-1:0] TYPE_CONS      = 16'h0002,
  parameter logic [DATA_WIDTH-1:0] TYPE_FUNC_PRIM = 16'h0003
) (
  input logic                clk,
  input logic                rst,
  heap_object_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, WR_TAG, WR_F0, WR_F1, DONE, ERR} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tag_q, field0_q, field1_q;
  logic [ADDR_WIDTH-1:0] heap_q, done_addr_q, addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ready_q, done_q, error_q, req_q;
  logic [1:0]            code_q;

  logic [1:0]            size_d;
  logic                  tag_ok_d, is_cons_d, fits_d, wr_last_d;
  logic [ADDR_WIDTH:0]   end_d;

  always_comb begin
    size_d   = 2'd0;
    tag_ok_d = 1'b0;
    if (tag_q == TYPE_NUMBER || tag_q == TYPE_FUNC_PRIM) begin
      size_d   = 2'd2;
      tag_ok_d = 1'b1;
    end else if (tag_q == TYPE_CONS) begin
      size_d   = 2'd3;
      tag_ok_d = 1'b1;
    end
  end

  assign is_cons_d = (tag_q == TYPE_CONS);
  // One extra bit so a heap_ptr near the top of the address space cannot wrap past the limit.
  assign end_d     = {1'b0, heap_q} + (ADDR_WIDTH+1)'(size_d);
  assign fits_d    = (end_d <= {1'b0, HEAP_LIMIT});
  assign wr_last_d = (state_q == WR_F1) || (state_q == WR_F0 && !is_cons_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      field0_q    <= '0;
      field1_q    <= '0;
      heap_q      <= HEAP_BASE;
      done_addr_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      req_q       <= 1'b0;
      code_q      <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.alloc_valid) begin
          tag_q    <= bus.alloc_tag;
          field0_q <= bus.alloc_field0;
          field1_q <= bus.alloc_field1;
          ready_q  <= 1'b0;
          state_q  <= CHECK;
        end
        CHECK: begin
          if (!tag_ok_d) begin
            error_q <= 1'b1;
            code_q  <= 2'd1;
            state_q <= ERR;
          end else if (!fits_d) begin
            error_q <= 1'b1;
            code_q  <= 2'd2;
            state_q <= ERR;
          end else begin
            req_q   <= 1'b1;
            addr_q  <= heap_q;
            wdata_q <= tag_q;
            state_q <= WR_TAG;
          end
        end
        WR_TAG, WR_F0, WR_F1: if (bus.mem_grant) begin
          if (wr_last_d) begin
            req_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b1;
            done_addr_q <= heap_q;
            heap_q      <= heap_q + ADDR_WIDTH'(size_d);
            state_q     <= DONE;
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            wdata_q <= (state_q == WR_TAG) ? field0_q : field1_q;
            state_q <= (state_q == WR_TAG) ? WR_F0 : WR_F1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alloc_ready      = ready_q;
  assign bus.done             = done_q;
  assign bus.done_addr        = done_addr_q;
  assign bus.error            = error_q;
  assign bus.error_code       = code_q;
  assign bus.heap_ptr         = heap_q;
  assign bus.mem_req          = req_q;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_write_data   = wdata_q;
  // The strobe must follow this cycle's grant, so it cannot be a pure register.
  assign bus.mem_write_enable = req_q & bus.mem_grant;

endmodule

// File: tb/tb_heap_object_writer.sv
// Randomized bench for heap_object_writer against a word-layout/heap-pointer model (small heap, limit 0x106).
module tb_heap_object_writer;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] LIMIT = 16'h0106;
  localparam logic [15:0] T_NUM = 16'h0001;
  localparam logic [15:0] T_CON = 16'h0002;
  localparam logic [15:0] T_PRM = 16'h0003;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  heap_object_writer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  heap_object_writer #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .HEAP_BASE(BASE), .HEAP_LIMIT(LIMIT),
    .TYPE_NUMBER(T_NUM), .TYPE_CONS(T_CON), .TYPE_FUNC_PRIM(T_PRM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int bad_we   = 0;
  logic [31:0] wq[$];
  logic [15:0] memarr [int];

  logic [15:0] m_hp;
  logic        m_err;
  logic [1:0]  m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      wq.push_back({bus.mem_addr, bus.mem_write_data});
      memarr[int'(bus.mem_addr)] = bus.mem_write_data;
      if (!bus.mem_grant) bad_we++;
    end
  end

  function automatic int obj_size(input logic [15:0] tag);
    if (tag == T_NUM || tag == T_PRM) return 2;
    if (tag == T_CON) return 3;
    return 0;
  endfunction

  task automatic check_reset_values();
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_done_addr", bus.done_addr, 0);
    check("rst_error", bus.error, 0);
    check("rst_code", bus.error_code, 0);
    check("rst_heap", bus.heap_ptr, BASE);
    check("rst_req", bus.mem_req, 0);
    check("rst_we", bus.mem_write_enable, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_data", bus.mem_write_data, 0);
  endtask

  // Starts and ends at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    bus.alloc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_hp = BASE; m_err = 1'b0; m_code = 2'd0;
    check_reset_values();
  endtask

  // gmode: 0 grant always high, 1 random grant, 2 grant low for 3 cycles of the field0 write.
  task automatic do_alloc(input logic [15:0] tag, input logic [15:0] f0, input logic [15:0] f1, input int gmode);
    int sz, k, stalls, stall_left, exp_lat;
    logic [1:0] exp_code;
    logic [15:0] words[3];
    logic g, prev_stall;
    logic [15:0] prev_addr, prev_data;
    logic seen;
    sz = obj_size(tag);
    words[0] = tag; words[1] = f0; words[2] = f1;
    exp_code = (sz == 0) ? 2'd1 : ((32'(m_hp) + sz > 32'(LIMIT)) ? 2'd2 : 2'd0);
    wq.delete();
    bus.alloc_tag = tag; bus.alloc_field0 = f0; bus.alloc_field1 = f1;
    bus.alloc_valid = 1'b1;
    if (m_err) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("err_ready", bus.alloc_ready, 0);
        check("err_sticky", {bus.error, bus.error_code}, {1'b1, m_code});
      end
      bus.alloc_valid = 1'b0;
      check("err_heap", bus.heap_ptr, m_hp);
      check("err_nowrite", wq.size(), 0);
      return;
    end
    k = 0;
    while (!bus.alloc_ready && k < 10) begin @(negedge clk); k++; end
    check("accept_ready", bus.alloc_ready, 1);
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.alloc_tag = 16'($urandom); bus.alloc_field0 = 16'($urandom); bus.alloc_field1 = 16'($urandom);
    k = 1; stalls = 0; stall_left = 3; prev_stall = 1'b0; seen = 1'b0;
    prev_addr = '0; prev_data = '0;
    while (k <= 40 && !seen) begin
      if (bus.done || bus.error) begin
        seen = 1'b1;
        check("end_code", bus.error_code, exp_code);
        check("end_done", bus.done, exp_code == 2'd0);
        if (exp_code != 2'd0) begin
          check("err_cycle", k, 2);
          check("err_nowrite", wq.size(), 0);
          check("err_heap", bus.heap_ptr, m_hp);
          m_err = 1'b1; m_code = exp_code;
        end else begin
          exp_lat = ((sz == 3) ? 5 : 4) + stalls;
          check("done_cycle", k, exp_lat);
          check("done_addr", bus.done_addr, m_hp);
          check("done_heap", bus.heap_ptr, m_hp + 16'(sz));
          check("nwrites", wq.size(), sz);
          for (int i = 0; i < sz && i < wq.size(); i++)
            check("write_word", wq[i], {m_hp + 16'(i), words[i]});
          m_hp = m_hp + 16'(sz);
          @(negedge clk);
          check("done_pulse", bus.done, 0);
        end
      end else begin
        if (gmode == 0) g = 1'b1;
        else if (gmode == 1) g = ($urandom_range(0, 3) != 0);
        else begin
          g = 1'b1;
          if (bus.mem_req && bus.mem_addr == m_hp + 16'd1 && stall_left > 0) begin
            g = 1'b0; stall_left--;
          end
        end
        bus.mem_grant = g;
        if (prev_stall) check("stall_stable", {bus.mem_addr, bus.mem_write_data}, {prev_addr, prev_data});
        prev_stall = bus.mem_req && !g;
        prev_addr = bus.mem_addr; prev_data = bus.mem_write_data;
        if (prev_stall) stalls++;
        #1;
        check("we_gated", bus.mem_write_enable, bus.mem_req && g);
        @(negedge clk);
        k++;
      end
    end
    if (!seen) check("timeout", 0, 1);
  endtask

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_tag = '0; bus.alloc_field0 = '0; bus.alloc_field1 = '0;
    bus.mem_grant = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    do_reset();

    do_alloc(T_NUM, 16'h002A, 16'h0000, 0);
    do_alloc(T_CON, 16'h0100, 16'h0000, 0);
    check("rd_car", memarr[16'h0103], 16'h0100);
    check("rd_cdr", memarr[16'h0104], 16'h0000);
    do_alloc(T_NUM, 16'h1234, 16'h0000, 0);
    check("oom_code", m_code, 2);

    do_reset();
    do_alloc(T_CON, 16'h1111, 16'h2222, 0);
    do_alloc(T_CON, 16'h3333, 16'h4444, 1);
    check("full_heap", bus.heap_ptr, 16'h0106);
    do_alloc(T_NUM, 16'h0005, 16'h0000, 0);
    do_alloc(T_PRM, 16'h0006, 16'h0000, 0);

    do_reset();
    do_alloc(T_CON, 16'hAAAA, 16'h5555, 2);

    do_reset();
    do_alloc(16'hBEEF, 16'h0001, 16'h0002, 0);
    check("badtag_code", m_code, 1);
    do_alloc(T_NUM, 16'h0001, 16'h0000, 0);

    do_reset();
    bus.alloc_tag = T_CON; bus.alloc_field0 = 16'h0123; bus.alloc_field1 = 16'h0456;
    bus.alloc_valid = 1'b1; bus.mem_grant = 1'b1;
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    for (int i = 0; i < 10 && !(bus.mem_req && bus.mem_addr == BASE + 16'd1); i++) @(negedge clk);
    check("midwr_in_f0", bus.mem_addr, BASE + 16'd1);
    do_reset();
    @(negedge clk);
    check("midwr_no_done", bus.done, 0);

    for (int it = 0; it < 40; it++) begin
      logic [15:0] t;
      if ((m_err && $urandom_range(0, 1) == 1) || $urandom_range(0, 11) == 0) do_reset();
      case ($urandom_range(0, 7))
        0, 1:    t = T_NUM;
        2, 3, 4: t = T_CON;
        5, 6:    t = T_PRM;
        default: t = 16'($urandom);
      endcase
      do_alloc(t, 16'($urandom), 16'($urandom), 1);
    end

    check("we_without_grant", bad_we, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
